// File: rtl/std_async_fifo_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO: synchronizes the write pointer,
// owns the binary/Gray read pointers and derives empty, fill level and underflow.
module std_async_fifo_rd_ctrl #(
    parameter int unsigned       WIDTH        = 32'd3,
    parameter int unsigned       SYNC_STAGES  = 32'd2,
    parameter logic [WIDTH:0]    ALMOST_EMPTY = (WIDTH+1)'(32'd1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WIDTH:0]       i_wr_ptr_gray,
    input  logic                 i_pop,
    output logic [WIDTH-1:0]     o_rd_addr,
    output logic [WIDTH:0]       o_rd_ptr_gray,
    output logic                 o_empty,
    output logic                 o_almost_empty,
    output logic [WIDTH:0]       o_count,
    output logic                 o_underflow
);

    function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
        logic [WIDTH:0] b;
        b[WIDTH] = g[WIDTH];
        for (int k = int'(WIDTH) - 1; k >= 0; k--) begin
            b[k] = g[k] ^ b[k+1];
        end
        return b;
    endfunction

    function automatic logic [WIDTH:0] bin2gray(input logic [WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH:0] sync_r [SYNC_STAGES];
    logic [WIDTH:0] wr_sync_gray_s;
    logic [WIDTH:0] wr_sync_bin_s;
    logic [WIDTH:0] rd_bin_r;
    logic [WIDTH:0] rd_bin_next_s;
    logic [WIDTH:0] rd_gray_r;
    logic [WIDTH:0] count_s;
    logic           empty_s;
    logic           almost_empty_s;
    logic           pop_accept_s;
    logic           underflow_r;

    // Write-pointer synchronizer chain; only the last stage feeds any logic.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= i_wr_ptr_gray;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign wr_sync_gray_s = sync_r[SYNC_STAGES-1];
    assign wr_sync_bin_s  = gray2bin(wr_sync_gray_s);

    // Status derived purely from flops so the async input never reaches an output.
    always_comb begin
        empty_s        = (rd_gray_r == wr_sync_gray_s);
        count_s        = wr_sync_bin_s - rd_bin_r;
        almost_empty_s = (count_s <= ALMOST_EMPTY);
        pop_accept_s   = i_pop & ~empty_s;
        rd_bin_next_s  = rd_bin_r;
        if (pop_accept_s) begin
            rd_bin_next_s = rd_bin_r + (WIDTH+1)'(32'd1);
        end else begin
            rd_bin_next_s = rd_bin_r;
        end
    end

    // Read pointer with a Gray copy updated on the same edge; underflow flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_bin_r    <= '0;
            rd_gray_r   <= '0;
            underflow_r <= 1'b0;
        end else begin
            rd_bin_r    <= rd_bin_next_s;
            rd_gray_r   <= bin2gray(rd_bin_next_s);
            underflow_r <= i_pop & empty_s;
        end
    end

    assign o_rd_addr      = rd_bin_r[WIDTH-1:0];
    assign o_rd_ptr_gray  = rd_gray_r;
    assign o_empty        = empty_s;
    assign o_almost_empty = almost_empty_s;
    assign o_count        = count_s;
    assign o_underflow    = underflow_r;

endmodule

// File: tb/tb_std_async_fifo_rd_ctrl.sv
// Directed self-checking bench for std_async_fifo_rd_ctrl (WIDTH=2, SYNC_STAGES=2).
module tb_std_async_fifo_rd_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [2:0] i_wr_ptr_gray = 3'b000;
    logic       i_pop = 1'b0;
    logic [1:0] o_rd_addr;
    logic [2:0] o_rd_ptr_gray;
    logic       o_empty;
    logic       o_almost_empty;
    logic [2:0] o_count;
    logic       o_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    std_async_fifo_rd_ctrl #(
        .WIDTH(32'd2), .SYNC_STAGES(32'd2), .ALMOST_EMPTY(3'd1)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr_ptr_gray(i_wr_ptr_gray), .i_pop(i_pop),
        .o_rd_addr(o_rd_addr), .o_rd_ptr_gray(o_rd_ptr_gray), .o_empty(o_empty),
        .o_almost_empty(o_almost_empty), .o_count(o_count), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        #2 i_rst = 1'b0;
        #1;
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %0b want 1", o_empty); end
        n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", o_count); end
        n_checks++; if (o_rd_ptr_gray !== 3'b000) begin n_fail++; $display("FAIL rst_gray: got %b want 000", o_rd_ptr_gray); end
        tick();
        tick();
        n_checks++; if (o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_almost: got %0b want 1", o_almost_empty); end
        n_checks++; if (o_rd_addr !== 2'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", o_rd_addr); end
        n_checks++; if (o_underflow !== 1'b0) begin n_fail++; $display("FAIL rst_uflow: got %0b want 0", o_underflow); end
        i_rst = 1'b1;
    endtask

    task automatic test_underflow();
        for (int p = 0; p < 2; p++) begin
            i_pop = 1'b1;
            tick();
            n_checks++; if (o_underflow !== 1'b1) begin n_fail++; $display("FAIL uflow_pulse%0d: got %0b want 1", p, o_underflow); end
            n_checks++; if (o_empty !== 1'b1 || o_count !== 3'd0) begin n_fail++; $display("FAIL uflow_state%0d: got empty=%0b count=%0d want 1/0", p, o_empty, o_count); end
            n_checks++; if (o_rd_addr !== 2'd0) begin n_fail++; $display("FAIL uflow_addr%0d: got %0d want 0", p, o_rd_addr); end
            i_pop = 1'b0;
            tick();
            n_checks++; if (o_underflow !== 1'b0) begin n_fail++; $display("FAIL uflow_clear%0d: got %0b want 0", p, o_underflow); end
        end
    endtask

    task automatic test_wr_latency();
        i_wr_ptr_gray = 3'b001;
        tick();
        n_checks++; if (o_empty !== 1'b1 || o_count !== 3'd0) begin n_fail++; $display("FAIL lat_k: got empty=%0b count=%0d want 1/0", o_empty, o_count); end
        tick();
        n_checks++; if (o_empty !== 1'b0 || o_count !== 3'd1) begin n_fail++; $display("FAIL lat_k1: got empty=%0b count=%0d want 0/1", o_empty, o_count); end
        n_checks++; if (o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL lat_almost: got %0b want 1", o_almost_empty); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_cnt  [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
        logic [1:0] exp_addr [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [2:0] exp_gray [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
        logic       exp_alm  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        i_wr_ptr_gray = 3'b110;
        tick();
        tick();
        n_checks++; if (o_count !== 3'd4 || o_empty !== 1'b0 || o_almost_empty !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got count=%0d empty=%0b alm=%0b want 4/0/0", o_count, o_empty, o_almost_empty); end
        n_checks++; if (o_rd_addr !== 2'd0 || o_rd_ptr_gray !== 3'b000) begin n_fail++; $display("FAIL b2b_start: got addr=%0d gray=%b want 0/000", o_rd_addr, o_rd_ptr_gray); end
        i_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (o_count !== exp_cnt[i]) begin n_fail++; $display("FAIL b2b_count%0d: got %0d want %0d", i, o_count, exp_cnt[i]); end
            n_checks++; if (o_rd_addr !== exp_addr[i]) begin n_fail++; $display("FAIL b2b_addr%0d: got %0d want %0d", i, o_rd_addr, exp_addr[i]); end
            n_checks++; if (o_rd_ptr_gray !== exp_gray[i]) begin n_fail++; $display("FAIL b2b_gray%0d: got %b want %b", i, o_rd_ptr_gray, exp_gray[i]); end
            n_checks++; if (o_almost_empty !== exp_alm[i]) begin n_fail++; $display("FAIL b2b_alm%0d: got %0b want %0b", i, o_almost_empty, exp_alm[i]); end
        end
        i_pop = 1'b0;
        n_checks++; if (o_empty !== 1'b1 || o_underflow !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got empty=%0b uflow=%0b want 1/0", o_empty, o_underflow); end
    endtask

    task automatic test_wrap();
        logic [2:0] wb = 3'd4;
        logic [2:0] prev;
        int written = 0;
        int popped = 0;
        for (int cyc = 0; cyc < 200 && popped < 20; cyc++) begin
            i_pop = ~o_empty;
            if (written < 20 && (written - popped) < 4) begin
                wb = wb + 3'd1;
                written++;
            end
            i_wr_ptr_gray = wb ^ (wb >> 1);
            prev = o_rd_ptr_gray;
            tick();
            if (i_pop) popped++;
            n_checks++; if (o_underflow !== 1'b0) begin n_fail++; $display("FAIL wrap_uflow c%0d: got %0b want 0", cyc, o_underflow); end
            n_checks++; if (o_count > 3'd4) begin n_fail++; $display("FAIL wrap_count c%0d: got %0d want <=4", cyc, o_count); end
            n_checks++; if ($countones(o_rd_ptr_gray ^ prev) > 1) begin n_fail++; $display("FAIL wrap_gray_step c%0d: got %b->%b want one-bit step", cyc, prev, o_rd_ptr_gray); end
        end
        i_pop = 1'b0;
        n_checks++; if (popped != 20) begin n_fail++; $display("FAIL wrap_timeout: got %0d pops want 20", popped); end
        n_checks++; if (o_rd_ptr_gray !== 3'b000 || o_rd_addr !== 2'd0) begin n_fail++; $display("FAIL wrap_final_ptr: got gray=%b addr=%0d want 000/0", o_rd_ptr_gray, o_rd_addr); end
        n_checks++; if (o_empty !== 1'b1 || o_count !== 3'd0) begin n_fail++; $display("FAIL wrap_final_empty: got empty=%0b count=%0d want 1/0", o_empty, o_count); end
        tick();
    endtask

    task automatic test_pop_on_advance_and_reset();
        i_wr_ptr_gray = 3'b001;
        i_pop = 1'b1;
        tick();
        n_checks++; if (o_underflow !== 1'b1 || o_empty !== 1'b1) begin n_fail++; $display("FAIL adv_k: got uflow=%0b empty=%0b want 1/1", o_underflow, o_empty); end
        tick();
        n_checks++; if (o_empty !== 1'b0 || o_count !== 3'd1) begin n_fail++; $display("FAIL adv_k1: got empty=%0b count=%0d want 0/1", o_empty, o_count); end
        i_wr_ptr_gray = 3'b011;
        tick();
        n_checks++; if (o_rd_addr !== 2'd1 || o_empty !== 1'b1 || o_underflow !== 1'b0) begin n_fail++; $display("FAIL adv_first_pop: got addr=%0d empty=%0b uflow=%0b want 1/1/0", o_rd_addr, o_empty, o_underflow); end
        i_pop = 1'b0;
        i_wr_ptr_gray = 3'b010;
        tick();
        n_checks++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL adv_k3: got count=%0d want 1", o_count); end
        i_pop = 1'b1;
        tick();
        n_checks++; if (o_count !== 3'd1 || o_rd_addr !== 2'd2 || o_rd_ptr_gray !== 3'b011) begin n_fail++; $display("FAIL adv_simul: got count=%0d addr=%0d gray=%b want 1/2/011", o_count, o_rd_addr, o_rd_ptr_gray); end
        i_pop = 1'b0;
        i_wr_ptr_gray = 3'b111;
        tick();
        tick();
        n_checks++; if (o_count !== 3'd3 || o_empty !== 1'b0 || o_almost_empty !== 1'b0) begin n_fail++; $display("FAIL mid_count3: got count=%0d empty=%0b alm=%0b want 3/0/0", o_count, o_empty, o_almost_empty); end
        #2 i_rst = 1'b0;
        i_wr_ptr_gray = 3'b000;
        #1;
        n_checks++; if (o_count !== 3'd0 || o_empty !== 1'b1 || o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_status: got count=%0d empty=%0b alm=%0b want 0/1/1", o_count, o_empty, o_almost_empty); end
        n_checks++; if (o_rd_addr !== 2'd0 || o_rd_ptr_gray !== 3'b000 || o_underflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ptr: got addr=%0d gray=%b uflow=%0b want 0/000/0", o_rd_addr, o_rd_ptr_gray, o_underflow); end
        tick();
        i_rst = 1'b1;
        tick();
        n_checks++; if (o_empty !== 1'b1 || o_count !== 3'd0) begin n_fail++; $display("FAIL post_rst: got empty=%0b count=%0d want 1/0", o_empty, o_count); end
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_wr_latency();
        test_back_to_back();
        test_wrap();
        test_pop_on_advance_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
